mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-RAM bus between the fetch unit, the load/store unit and one single-port RAM.
// The arbiter takes the slave side; the cores and the RAM together make up the master side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_gnt_o;
  logic              inst_rvalid_o;
  logic [DATA_W-1:0] inst_rdata_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              flush_i;
  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic              stallreq_if_o;
  logic              stallreq_mem_o;

  modport slave (
    input  inst_req_i, inst_addr_i, data_req_i, data_we_i, data_addr_i, data_wdata_i,
           flush_i, ram_rdata_i,
    output inst_gnt_o, inst_rvalid_o, inst_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
           ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, stallreq_if_o, stallreq_mem_o
  );

  modport master (
    output inst_req_i, inst_addr_i, data_req_i, data_we_i, data_addr_i, data_wdata_i,
           flush_i, ram_rdata_i,
    input  inst_gnt_o, inst_rvalid_o, inst_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
           ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, stallreq_if_o, stallreq_mem_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: loads/stores win by default, fetch wins when data is idle or
// after STARVE_MAX denied cycles. A small response FSM routes the 1-cycle read data back.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD, DATA_WR} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic w_starved, w_inst_gnt, w_data_gnt, w_inst_rv, w_data_rv;

  // Grants are qualified with reset so every combinational output is low while rst_i=0.
  assign w_starved  = (r_starve == CNT_W'(STARVE_MAX));
  assign w_inst_gnt = rst_i & bus.inst_req_i & (~bus.data_req_i | w_starved);
  assign w_data_gnt = rst_i & bus.data_req_i & ~w_inst_gnt;
  assign w_inst_rv  = (r_state == INST_RD) & ~bus.flush_i;
  assign w_data_rv  = (r_state == DATA_RD);

  assign bus.inst_gnt_o     = w_inst_gnt;
  assign bus.data_gnt_o     = w_data_gnt;
  assign bus.stallreq_if_o  = rst_i & bus.inst_req_i & ~w_inst_gnt;
  assign bus.stallreq_mem_o = rst_i & bus.data_req_i & ~w_data_gnt;
  assign bus.ram_ce_o       = w_inst_gnt | w_data_gnt;
  assign bus.ram_we_o       = w_data_gnt & bus.data_we_i;
  assign bus.inst_rvalid_o  = w_inst_rv;
  assign bus.data_rvalid_o  = w_data_rv;

  // Read data is forwarded in its valid cycle and then held in the port register.
  assign bus.inst_rdata_o = w_inst_rv ? bus.ram_rdata_i : r_inst_rdata;
  assign bus.data_rdata_o = w_data_rv ? bus.ram_rdata_i : r_data_rdata;

  always_comb begin
    bus.ram_addr_o  = r_addr;
    bus.ram_wdata_o = r_wdata;
    if (w_inst_gnt) begin
      bus.ram_addr_o = bus.inst_addr_i;
    end else if (w_data_gnt) begin
      bus.ram_addr_o  = bus.data_addr_i;
      bus.ram_wdata_o = bus.data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_starve     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_inst_gnt)                     r_state <= INST_RD;
      else if (w_data_gnt && bus.data_we_i) r_state <= DATA_WR;
      else if (w_data_gnt)                r_state <= DATA_RD;
      else                                r_state <= IDLE;

      if (bus.flush_i || !bus.inst_req_i || w_inst_gnt) r_starve <= '0;
      else if (!w_starved)                              r_starve <= r_starve + CNT_W'(1);

      if (w_inst_gnt) r_addr <= bus.inst_addr_i;
      if (w_data_gnt) begin
        r_addr  <= bus.data_addr_i;
        r_wdata <= bus.data_wdata_i;
      end

      if (w_inst_rv) r_inst_rdata <= bus.ram_rdata_i;
      if (w_data_rv) r_data_rdata <= bus.ram_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized plus directed bench for mem_arbiter; a behavioural RAM sits on the bus and a
// cycle-level transaction model predicts every output.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  // Behavioural synchronous single-port RAM
  logic [DW-1:0] ram [256];
  always @(posedge clk_i)
    if (bus.ram_ce_o) begin
      if (bus.ram_we_o) ram[bus.ram_addr_o[7:0]] <= bus.ram_wdata_o;
      else              bus.ram_rdata_i <= ram[bus.ram_addr_o[7:0]];
    end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] iv(input int i);
    return (32'h9E3779B9 * i) ^ 32'hC0FFEE00;
  endfunction

  // Reference model state: outstanding read owner, port hold values, shadow memory
  logic [DW-1:0] sh [256];
  int            m_starve, m_pend;     // m_pend: 0 none, 1 fetch read, 2 data read
  logic [7:0]    m_paddr;
  logic [DW-1:0] m_ihold, m_dhold, m_laddr, m_lwd;
  logic          e_gi, e_gd;
  logic          o_gi, o_gd, o_sif, o_smem, o_we, o_irv, o_drv;
  logic [DW-1:0] o_ird, o_drd;

  task automatic model_reset();
    m_starve = 0; m_pend = 0; m_paddr = '0;
    m_ihold = '0; m_dhold = '0; m_laddr = '0; m_lwd = '0;
  endtask

  task automatic cycle();
    logic gi, gd, irv, drv;
    @(negedge clk_i);
    gi  = bus.inst_req_i && (!bus.data_req_i || m_starve == SMAX);
    gd  = bus.data_req_i && !gi;
    irv = (m_pend == 1) && !bus.flush_i;
    drv = (m_pend == 2);
    chk("inst_gnt", bus.inst_gnt_o, gi);
    chk("data_gnt", bus.data_gnt_o, gd);
    chk("stall_if", bus.stallreq_if_o, bus.inst_req_i && !gi);
    chk("stall_mem", bus.stallreq_mem_o, bus.data_req_i && !gd);
    chk("ram_ce", bus.ram_ce_o, gi || gd);
    chk("ram_we", bus.ram_we_o, gd && bus.data_we_i);
    if (gi)      chk("ram_addr_i", bus.ram_addr_o, bus.inst_addr_i);
    else if (gd) chk("ram_addr_d", bus.ram_addr_o, bus.data_addr_i);
    else         chk("ram_addr_hold", bus.ram_addr_o, m_laddr);
    if (gd && bus.data_we_i) chk("ram_wdata", bus.ram_wdata_o, bus.data_wdata_i);
    else if (!gi && !gd)     chk("ram_wdata_hold", bus.ram_wdata_o, m_lwd);
    chk("inst_rvalid", bus.inst_rvalid_o, irv);
    chk("data_rvalid", bus.data_rvalid_o, drv);
    chk("inst_rdata", bus.inst_rdata_o, irv ? sh[m_paddr] : m_ihold);
    chk("data_rdata", bus.data_rdata_o, drv ? sh[m_paddr] : m_dhold);
    e_gi = gi; e_gd = gd;
    o_gi = bus.inst_gnt_o; o_gd = bus.data_gnt_o; o_sif = bus.stallreq_if_o;
    o_smem = bus.stallreq_mem_o; o_we = bus.ram_we_o; o_irv = bus.inst_rvalid_o;
    o_drv = bus.data_rvalid_o; o_ird = bus.inst_rdata_o; o_drd = bus.data_rdata_o;
    @(posedge clk_i);
    if (irv) m_ihold = sh[m_paddr];
    if (drv) m_dhold = sh[m_paddr];
    if (gd && bus.data_we_i) sh[bus.data_addr_i[7:0]] = bus.data_wdata_i;
    if (bus.flush_i || !bus.inst_req_i || gi) m_starve = 0;
    else if (m_starve < SMAX)                 m_starve++;
    m_pend = gi ? 1 : (gd && !bus.data_we_i) ? 2 : 0;
    if (gi) begin
      m_paddr = bus.inst_addr_i[7:0]; m_laddr = bus.inst_addr_i;
    end else if (gd) begin
      m_paddr = bus.data_addr_i[7:0]; m_laddr = bus.data_addr_i; m_lwd = bus.data_wdata_i;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req_i = 0; bus.inst_addr_i = '0; bus.data_req_i = 0; bus.data_we_i = 0;
    bus.data_addr_i = '0; bus.data_wdata_i = '0; bus.flush_i = 0;
  endtask

  initial begin
    int first;
    logic smem_at;
    bit ipend, dpend;
    for (int i = 0; i < 256; i++) begin ram[i] = iv(i); sh[i] = iv(i); end
    ram[8'h10] = 32'hDEADBEEF; sh[8'h10] = 32'hDEADBEEF;
    idle_inputs();
    model_reset();
    // Reset state with both requests asserted: everything forced low
    bus.inst_req_i = 1; bus.data_req_i = 1; bus.data_we_i = 1;
    #2;
    chk("rst_inst_gnt", bus.inst_gnt_o, 0);
    chk("rst_data_gnt", bus.data_gnt_o, 0);
    chk("rst_stall_if", bus.stallreq_if_o, 0);
    chk("rst_stall_mem", bus.stallreq_mem_o, 0);
    chk("rst_ce", bus.ram_ce_o, 0);
    chk("rst_we", bus.ram_we_o, 0);
    chk("rst_addr", bus.ram_addr_o, 0);
    chk("rst_inst_rdata", bus.inst_rdata_o, 0);
    @(posedge clk_i); #1;
    idle_inputs();
    rst_i = 1;

    // Fetch only
    bus.inst_req_i = 1; bus.inst_addr_i = 32'h10;
    cycle(); chk("fo_gnt", o_gi, 1);
    bus.inst_req_i = 0;
    cycle(); chk("fo_rvalid", o_irv, 1); chk("fo_rdata", o_ird, 32'hDEADBEEF);

    // Simultaneous load + fetch
    bus.data_req_i = 1; bus.data_addr_i = 32'h20; bus.inst_req_i = 1; bus.inst_addr_i = 32'h14;
    cycle(); chk("sim_dgnt", o_gd, 1); chk("sim_stall_if", o_sif, 1);
    bus.data_req_i = 0;
    cycle(); chk("sim_ignt", o_gi, 1); chk("sim_drv", o_drv, 1); chk("sim_drd", o_drd, iv(32'h20));
    bus.inst_req_i = 0;
    cycle(); chk("sim_ird", o_ird, iv(32'h14));

    // Starvation: data held busy for 10 cycles, fetch pending
    first = 0; smem_at = 0;
    bus.inst_req_i = 1; bus.inst_addr_i = 32'h18; bus.data_req_i = 1;
    for (int k = 1; k <= 10; k++) begin
      bus.data_addr_i = 32'h30 + k;
      cycle();
      if (o_gi && first == 0) begin first = k; smem_at = o_smem; end
      if (e_gi) bus.inst_req_i = 0;
    end
    chk("starve_cycle", first, 5);
    chk("starve_stall_mem", smem_at, 1);
    idle_inputs();
    cycle();

    // Store then load to 0x40
    bus.data_req_i = 1; bus.data_we_i = 1; bus.data_addr_i = 32'h40; bus.data_wdata_i = 32'h12345678;
    cycle(); chk("st_we", o_we, 1);
    bus.data_we_i = 0; bus.data_wdata_i = '0;
    cycle(); chk("st_no_rv", o_drv, 0); chk("ld_we", o_we, 0);
    bus.data_req_i = 0;
    cycle(); chk("ld_rv", o_drv, 1); chk("ld_rdata", o_drd, 32'h12345678);

    // Flush in the cycle after a fetch grant
    bus.inst_req_i = 1; bus.inst_addr_i = 32'h44;
    cycle();
    bus.inst_req_i = 0; bus.flush_i = 1;
    cycle(); chk("fl_rv", o_irv, 0); chk("fl_rdata", o_ird, iv(32'h18));
    bus.flush_i = 0;

    // Reset asserted while a load is in flight
    bus.data_req_i = 1; bus.data_addr_i = 32'h40;
    cycle();
    bus.data_req_i = 0; bus.inst_req_i = 1;
    rst_i = 0; #1;
    chk("ar_drv", bus.data_rvalid_o, 0);
    chk("ar_drd", bus.data_rdata_o, 0);
    chk("ar_ird", bus.inst_rdata_o, 0);
    chk("ar_stall_if", bus.stallreq_if_o, 0);
    chk("ar_ce", bus.ram_ce_o, 0);
    chk("ar_addr", bus.ram_addr_o, 0);
    chk("ar_wdata", bus.ram_wdata_o, 0);
    @(posedge clk_i); #1;
    idle_inputs(); model_reset();
    rst_i = 1;
    cycle(); chk("ar_no_rv", o_drv, 0);

    // Randomized traffic; requesters hold request and payload until granted
    ipend = 0; dpend = 0;
    repeat (600) begin
      if (!ipend && $urandom_range(0, 2) != 0) begin
        ipend = 1; bus.inst_addr_i = 32'($urandom_range(0, 31));
      end
      if (!dpend && $urandom_range(0, 3) != 0) begin
        dpend = 1; bus.data_we_i = 1'($urandom_range(0, 1));
        bus.data_addr_i = 32'($urandom_range(0, 31)); bus.data_wdata_i = $urandom;
      end
      bus.inst_req_i = ipend; bus.data_req_i = dpend;
      bus.flush_i = ($urandom_range(0, 9) == 0);
      cycle();
      if (e_gi) ipend = 0;
      if (e_gd) dpend = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
